// File: rtl/compress_sched_if.sv
// Stream and datapath-control bundle for compress_sched.
// master = pixel source / packer side, slave = scheduler.
interface compress_sched_if #(
  parameter int PIX_W = 512,
  parameter int IDX_W = 8
);
  logic             start;
  logic [IDX_W:0]   frame_tiles;
  logic             busy;
  logic             done;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixels;
  logic [PIX_W-1:0] pipe_pixels;
  logic             pipe_en;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_tile_idx;

  modport master (
    output start, frame_tiles,
    output in_valid, in_pixels,
    output out_ready,
    input  busy, done, in_ready,
    input  pipe_pixels, pipe_en,
    input  out_valid, out_tile_idx
  );

  modport slave (
    input  start, frame_tiles,
    input  in_valid, in_pixels,
    input  out_ready,
    output busy, done, in_ready,
    output pipe_pixels, pipe_en,
    output out_valid, out_tile_idx
  );
endinterface

// File: rtl/compress_sched.sv
// Tile issue scheduler for the header/residual compression pipe.
// COMPRESS_SCHED_PERF_EN adds the stall_cycles perf counter port.
module compress_sched #(
  parameter int PIPE_DEPTH = 2,
  parameter int PIX_W      = 512,
  parameter int MAX_TILES  = 256,
  parameter int IDX_W      = $clog2(MAX_TILES)
) (
  input  logic        clk,
  input  logic        rst,
`ifdef COMPRESS_SCHED_PERF_EN
  output logic [31:0] stall_cycles,
`endif
  compress_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, DONE
  } state_t;

  localparam logic [IDX_W:0] ONE =
    {{IDX_W{1'b0}}, 1'b1};

  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic [IDX_W:0]   total_q;
  logic [IDX_W:0]   issued_q;
  logic [IDX_W:0]   retired_q;
  logic [IDX_W:0]   retired_d;
  logic [PIPE_DEPTH-1:0] vld_q;
  logic [IDX_W-1:0] idx_q [PIPE_DEPTH];
  logic [PIX_W-1:0] pix_q;
  logic             pipe_en;
  logic             in_rdy;
  logic             accept;
  logic             retire;

  assign pipe_en =
    !(vld_q[PIPE_DEPTH-1] && !bus.out_ready);
  assign in_rdy = (state_q == RUN) && pipe_en
               && (issued_q < total_q);
  assign accept = bus.in_valid && in_rdy;
  assign retire = vld_q[PIPE_DEPTH-1]
               && bus.out_ready;
  assign retired_d = retire ? retired_q + ONE
                            : retired_q;

  assign bus.in_ready     = in_rdy;
  assign bus.pipe_en      = pipe_en;
  assign bus.pipe_pixels  = pix_q;
  assign bus.out_valid    = vld_q[PIPE_DEPTH-1];
  assign bus.out_tile_idx = idx_q[PIPE_DEPTH-1];
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

  // Frame FSM with issue/retire counters and registered busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      total_q   <= '0;
      issued_q  <= '0;
      retired_q <= '0;
    end else begin
      done_q    <= 1'b0;
      retired_q <= retired_d;
      if (accept)
        issued_q <= issued_q + ONE;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            total_q   <= bus.frame_tiles;
            issued_q  <= '0;
            retired_q <= '0;
            if (bus.frame_tiles == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issued_q == total_q) begin
            if (retired_d == total_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (retired_d == total_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Slot-valid/index shift register; frozen while the tail stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      pix_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++)
        idx_q[i] <= '0;
    end else if (pipe_en) begin
      vld_q <= {vld_q[PIPE_DEPTH-2:0], accept};
      for (int i = PIPE_DEPTH-1; i > 0; i--)
        idx_q[i] <= idx_q[i-1];
      if (accept) begin
        pix_q    <= bus.in_pixels;
        idx_q[0] <= issued_q[IDX_W-1:0];
      end
    end
  end

`ifdef COMPRESS_SCHED_PERF_EN
  logic [31:0] stall_q;
  logic        start_ok;

  assign start_ok     = (state_q == IDLE) && bus.start;
  assign stall_cycles = stall_q;

  // Saturating count of busy cycles lost to downstream backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if (busy_q && !pipe_en
                 && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end
`endif

endmodule
